reg_file_wb: RTL and testbench
==============================

REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 Parameter: size, default 32, data width of every register and data port.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 RSaddr_i  input  5  read port A register index.
REQ-005 RTaddr_i  input  5  read port B register index.
REQ-006 RDaddr_i  input  5  write-back destination index.
REQ-007 RDdata_i  input  size  write-back data, driven by the write-back select mux output.
REQ-008 RegWrite_i  input  1  write-back enable.
REQ-009 busy_set_i  input  1  marks busy_addr_i pending, for example on issue of a multi-cycle load.
REQ-010 busy_addr_i  input  5  register index to mark pending.
REQ-011 RSdata_o  output  size  read port A data.
REQ-012 RTdata_o  output  size  read port B data.
REQ-013 RSbusy_o  output  1  register RSaddr_i has a pending write.
REQ-014 RTbusy_o  output  1  register RTaddr_i has a pending write.
REQ-015 wr_cnt_o  output  16  count of committed register writes.

Function
REQ-016 Storage SHALL be 32 registers of size bits, plus one 32-bit busy vector.
REQ-017 A commit SHALL occur on a rising edge when RegWrite_i=1, RDaddr_i!=0 and rst_i=0; regs[RDaddr_i] takes RDdata_i.
REQ-018 Register 0 SHALL always read 0; writes and busy sets targeting it SHALL be ignored.
REQ-019 Reads SHALL be combinational: RSdata_o=regs[RSaddr_i], RTdata_o=regs[RTaddr_i].
REQ-020 Write-through bypass: a same-cycle commit whose RDaddr_i equals a nonzero read address SHALL drive RDdata_i on that read port, giving zero-latency write-to-read.
REQ-021 A commit SHALL clear busy[RDaddr_i] at the same edge.
REQ-022 busy_set_i=1 with busy_addr_i!=0 SHALL set busy[busy_addr_i] at the edge.
REQ-023 Simultaneous set and commit to the same index: set SHALL win, so busy ends 1 and the data still commits.
REQ-024 RSbusy_o/RTbusy_o SHALL be busy[addr] AND NOT (a same-cycle commit to that addr); address 0 SHALL always report 0.
REQ-025 wr_cnt_o SHALL increment by 1 per commit and saturate at 16'hFFFF without wrapping.
REQ-026 Both read ports addressing the same register SHALL return identical data and busy values.
REQ-027 RegWrite_i=0 SHALL leave the registers and wr_cnt_o unchanged regardless of RDaddr_i/RDdata_i.

Reset
REQ-028 With rst_i=1 at an edge: all registers SHALL become 0 except register 29, which SHALL become 128 (stack pointer).
REQ-029 The same reset edge SHALL clear the busy vector and set wr_cnt_o to 0.
REQ-030 Reset SHALL dominate any same-edge commit or busy set.
REQ-031 Read-port bypass SHALL stay combinational while rst_i=1.

Verification
REQ-032 Reset, then read RS=29, RT=5 -> RSdata_o=128, RTdata_o=0, both busy 0, wr_cnt_o=0.
REQ-033 Write r8=0xDEADBEEF with RSaddr_i=8 in the same cycle -> RSdata_o=0xDEADBEEF before the edge; after the edge it still reads 0xDEADBEEF and wr_cnt_o=1.
REQ-034 RegWrite_i=1 to r0 with 0x1234, then read r0 -> 0; wr_cnt_o unchanged.
REQ-035 busy_set r9 -> RSbusy_o=1 at RS=9; next cycle commit r9 -> busy 0 in the commit cycle and after; a simultaneous set+commit on r9 -> busy 1 after the edge.
REQ-036 Preload wr_cnt_o to 0xFFFE via 2 further commits -> 0xFFFF, and a further commit holds 0xFFFF.
REQ-037 Assert rst_i mid-stream with a pending commit to r3 and busy r4 -> r3=0, busy r4 cleared, r29=128, wr_cnt_o=0.

Source files
------------

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// reg_file_wb : 32-entry register file, write-through bypass, busy scoreboard
// Revision    : 1.0
// ============================================================================
module reg_file_wb #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      RSaddr_i,
  input  logic [4:0]      RTaddr_i,
  input  logic [4:0]      RDaddr_i,
  input  logic [size-1:0] RDdata_i,
  input  logic            RegWrite_i,
  input  logic            busy_set_i,
  input  logic [4:0]      busy_addr_i,
  output logic [size-1:0] RSdata_o,
  output logic [size-1:0] RTdata_o,
  output logic            RSbusy_o,
  output logic            RTbusy_o,
  output logic [15:0]     wr_cnt_o
);

  localparam logic [size-1:0] C_SP_INIT = size'(32'd128);
  localparam logic [15:0]     C_CNT_MAX = 16'hFFFF;

  logic [size-1:0] regs_q [32];
  logic [31:0]     busy_q, busy_d;
  logic [15:0]     wr_cnt_q, wr_cnt_d;

  logic w_wb_en;
  logic w_commit;
  logic w_rs_hit;
  logic w_rt_hit;

  // Bypass qualifies on the write enable alone so reads stay combinational in reset.
  assign w_wb_en  = RegWrite_i && (RDaddr_i != 5'd0);
  assign w_commit = w_wb_en && !rst_i;
  assign w_rs_hit = w_wb_en && (RDaddr_i == RSaddr_i);
  assign w_rt_hit = w_wb_en && (RDaddr_i == RTaddr_i);

  always_comb begin
    busy_d = busy_q;
    if (w_commit) begin
      busy_d[RDaddr_i] = 1'b0;
    end
    // A set issued alongside a commit to the same index must win.
    if (busy_set_i && (busy_addr_i != 5'd0)) begin
      busy_d[busy_addr_i] = 1'b1;
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (w_commit && (wr_cnt_q != C_CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 29) ? C_SP_INIT : '0;
      end
      busy_q   <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (w_commit) begin
        regs_q[RDaddr_i] <= RDdata_i;
      end
      busy_q   <= busy_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    RSdata_o = '0;
    RTdata_o = '0;
    if (RSaddr_i != 5'd0) begin
      RSdata_o = w_rs_hit ? RDdata_i : regs_q[RSaddr_i];
    end
    if (RTaddr_i != 5'd0) begin
      RTdata_o = w_rt_hit ? RDdata_i : regs_q[RTaddr_i];
    end
  end

  assign RSbusy_o = (RSaddr_i != 5'd0) && busy_q[RSaddr_i] &&
                    !(w_commit && (RDaddr_i == RSaddr_i));
  assign RTbusy_o = (RTaddr_i != 5'd0) && busy_q[RTaddr_i] &&
                    !(w_commit && (RDaddr_i == RTaddr_i));
  assign wr_cnt_o = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// tb_reg_file_wb : randomized self-checking bench against a behavioural model
// Revision       : 1.0
// ============================================================================
module tb_reg_file_wb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i, busy_addr_i;
  logic [31:0] RDdata_i;
  logic        RegWrite_i, busy_set_i;
  logic [31:0] RSdata_o, RTdata_o;
  logic        RSbusy_o, RTbusy_o;
  logic [15:0] wr_cnt_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_cnt;

  reg_file_wb #(.size(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .RDdata_i(RDdata_i), .RegWrite_i(RegWrite_i),
    .busy_set_i(busy_set_i), .busy_addr_i(busy_addr_i),
    .RSdata_o(RSdata_o), .RTdata_o(RTdata_o),
    .RSbusy_o(RSbusy_o), .RTbusy_o(RTbusy_o), .wr_cnt_o(wr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected read value for the current (pre-edge) inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (RegWrite_i && RDaddr_i != 0 && RDaddr_i == a) return RDdata_i;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (RegWrite_i && !rst_i && RDaddr_i == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply the architectural effect of the current inputs, then cross the edge.
  task automatic tick();
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = (i == 29) ? 32'd128 : 32'd0;
        m_busy[i] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      if (RegWrite_i && RDaddr_i != 0) begin
        m_regs[RDaddr_i] = RDdata_i;
        m_busy[RDaddr_i] = 1'b0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      if (busy_set_i && busy_addr_i != 0) m_busy[busy_addr_i] = 1'b1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rst_i = 0; RegWrite_i = 0; busy_set_i = 0;
    RDaddr_i = 0; RDdata_i = 0; busy_addr_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
    RSaddr_i = 5'd29; RTaddr_i = 5'd5;
    #1;
    total_cnt++;
    if (RSdata_o !== 32'd128) $display("FAIL reset_r29 got %h want %h", RSdata_o, 32'd128);
    else pass_cnt++;
    total_cnt++;
    if (RTdata_o !== 32'd0) $display("FAIL reset_r5 got %h want 0", RTdata_o);
    else pass_cnt++;
    total_cnt++;
    if ({RSbusy_o, RTbusy_o} !== 2'b00) $display("FAIL reset_busy got %b want 00", {RSbusy_o, RTbusy_o});
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt_o !== 16'd0) $display("FAIL reset_cnt got %0d want 0", wr_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    idle();
    RegWrite_i = 1; RDaddr_i = 5'd8; RDdata_i = 32'hDEADBEEF; RSaddr_i = 5'd8;
    #1;
    total_cnt++;
    if (RSdata_o !== 32'hDEADBEEF) $display("FAIL bypass_pre got %h want DEADBEEF", RSdata_o);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (RSdata_o !== 32'hDEADBEEF) $display("FAIL bypass_post got %h want DEADBEEF", RSdata_o);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt_o !== 16'd1) $display("FAIL bypass_cnt got %0d want 1", wr_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_r0();
    idle();
    RegWrite_i = 1; RDaddr_i = 5'd0; RDdata_i = 32'h1234;
    busy_set_i = 1; busy_addr_i = 5'd0; RSaddr_i = 5'd0; RTaddr_i = 5'd0;
    #1;
    total_cnt++;
    if (RSdata_o !== 32'd0) $display("FAIL r0_bypass got %h want 0", RSdata_o);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (RTdata_o !== 32'd0 || RTbusy_o !== 1'b0) $display("FAIL r0_read got %h/%b want 0/0", RTdata_o, RTbusy_o);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt_o !== 16'(m_cnt)) $display("FAIL r0_cnt got %0d want %0d", wr_cnt_o, m_cnt);
    else pass_cnt++;
  endtask

  task automatic test_busy();
    idle();
    busy_set_i = 1; busy_addr_i = 5'd9; RSaddr_i = 5'd9; RTaddr_i = 5'd9;
    tick();
    idle();
    #1;
    total_cnt++;
    if (RSbusy_o !== 1'b1 || RTbusy_o !== 1'b1) $display("FAIL busy_set got %b%b want 11", RSbusy_o, RTbusy_o);
    else pass_cnt++;
    RegWrite_i = 1; RDaddr_i = 5'd9; RDdata_i = 32'hA5A5_0009;
    #1;
    total_cnt++;
    if (RSbusy_o !== 1'b0) $display("FAIL busy_commit_cycle got %b want 0", RSbusy_o);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (RSbusy_o !== 1'b0) $display("FAIL busy_after_commit got %b want 0", RSbusy_o);
    else pass_cnt++;
    RegWrite_i = 1; RDaddr_i = 5'd9; RDdata_i = 32'h0BAD_F00D;
    busy_set_i = 1; busy_addr_i = 5'd9;
    tick();
    idle();
    #1;
    total_cnt++;
    if (RSbusy_o !== 1'b1 || RSdata_o !== 32'h0BAD_F00D)
      $display("FAIL busy_set_wins got %b/%h want 1/0badf00d", RSbusy_o, RSdata_o);
    else pass_cnt++;
    // Clear r9 so later random traffic starts from a known scoreboard.
    RegWrite_i = 1; RDaddr_i = 5'd9; RDdata_i = 32'h9;
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [31:0] e_rs, e_rt;
    logic        b_rs, b_rt;
    for (int n = 0; n < 300; n++) begin
      rst_i       = 1'b0;
      RegWrite_i  = ($urandom_range(0, 3) != 0);
      RDaddr_i    = 5'($urandom_range(0, 31));
      RDdata_i    = $urandom;
      busy_set_i  = ($urandom_range(0, 2) == 0);
      busy_addr_i = 5'($urandom_range(0, 31));
      RSaddr_i    = ($urandom_range(0, 3) == 0) ? RDaddr_i : 5'($urandom_range(0, 31));
      RTaddr_i    = ($urandom_range(0, 4) == 0) ? RSaddr_i : 5'($urandom_range(0, 31));
      #1;
      e_rs = exp_rd(RSaddr_i); e_rt = exp_rd(RTaddr_i);
      b_rs = exp_busy(RSaddr_i); b_rt = exp_busy(RTaddr_i);
      total_cnt++;
      if (RSdata_o !== e_rs || RSbusy_o !== b_rs)
        $display("FAIL rand_rs[%0d] a=%0d got %h/%b want %h/%b", n, RSaddr_i, RSdata_o, RSbusy_o, e_rs, b_rs);
      else pass_cnt++;
      total_cnt++;
      if (RTdata_o !== e_rt || RTbusy_o !== b_rt)
        $display("FAIL rand_rt[%0d] a=%0d got %h/%b want %h/%b", n, RTaddr_i, RTdata_o, RTbusy_o, e_rt, b_rt);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (wr_cnt_o !== 16'(m_cnt)) $display("FAIL rand_cnt[%0d] got %0d want %0d", n, wr_cnt_o, m_cnt);
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_saturate();
    idle();
    RegWrite_i = 1; RDaddr_i = 5'd12;
    while (m_cnt < 16'hFFFE) begin
      RDdata_i = 32'(m_cnt);
      tick();
    end
    total_cnt++;
    if (wr_cnt_o !== 16'hFFFE) $display("FAIL sat_preload got %h want FFFE", wr_cnt_o);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (wr_cnt_o !== 16'hFFFF) $display("FAIL sat_reach got %h want FFFF", wr_cnt_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (wr_cnt_o !== 16'hFFFF) $display("FAIL sat_hold got %h want FFFF", wr_cnt_o);
    else pass_cnt++;
    idle();
    tick();
    total_cnt++;
    if (wr_cnt_o !== 16'hFFFF) $display("FAIL sat_nowrite got %h want FFFF", wr_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_midstream_reset();
    idle();
    RegWrite_i = 1; RDaddr_i = 5'd3; RDdata_i = 32'h3333_3333;
    busy_set_i = 1; busy_addr_i = 5'd4;
    tick();
    RDdata_i = 32'h7777_7777;
    rst_i = 1;
    tick();
    idle();
    RSaddr_i = 5'd3; RTaddr_i = 5'd4;
    #1;
    total_cnt++;
    if (RSdata_o !== 32'd0) $display("FAIL mid_r3 got %h want 0", RSdata_o);
    else pass_cnt++;
    total_cnt++;
    if (RTbusy_o !== 1'b0) $display("FAIL mid_busy4 got %b want 0", RTbusy_o);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt_o !== 16'd0) $display("FAIL mid_cnt got %0d want 0", wr_cnt_o);
    else pass_cnt++;
    RSaddr_i = 5'd29;
    #1;
    total_cnt++;
    if (RSdata_o !== 32'd128) $display("FAIL mid_r29 got %h want 128", RSdata_o);
    else pass_cnt++;
  endtask

  initial begin
    idle();
    RSaddr_i = 0; RTaddr_i = 0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 0;
      m_busy[i] = 0;
    end
    m_cnt = 0;
    test_reset();
    test_bypass();
    test_r0();
    test_busy();
    test_random();
    test_saturate();
    test_midstream_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
